// File: rtl/sparrow_mem_arbiter.sv
// Arbitrates the sparrow core's fetch and data ports onto one single-port memory.
// Data has priority; a starvation counter forces a fetch grant after STARVE_LIMIT losses.
module sparrow_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned DATA_W       = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_imem_req,
  input  logic [31:0]       i_imem_addr,
  output logic              o_imem_gnt,
  output logic              o_imem_rvalid,
  output logic [DATA_W-1:0] o_imem_rdata,
  input  logic              i_dmem_req,
  input  logic [31:0]       i_dmem_addr,
  input  logic [1:0]        i_dmem_byte_en,
  input  logic              i_dmem_wr_en,
  input  logic [DATA_W-1:0] i_dmem_wr_data,
  output logic              o_dmem_gnt,
  output logic              o_dmem_rvalid,
  output logic [DATA_W-1:0] o_dmem_rdata,
  output logic              o_mem_req,
  output logic [31:0]       o_mem_addr,
  output logic [1:0]        o_mem_byte_en,
  output logic              o_mem_wr_en,
  output logic [DATA_W-1:0] o_mem_wr_data,
  input  logic              i_mem_ready,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  // Size-code encoding shared with sparrow_pkg: BYTE=0, HALF_WORD=1, WORD=2.
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [3:0] LIMIT   = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {OWN_NONE, OWN_IMEM, OWN_DMEM} owner_e;

  logic [3:0] starve_cnt, starve_nxt;
  owner_e     rd_owner, rd_owner_nxt;
  logic       imem_win, dmem_win, imem_gnt, dmem_gnt;

  always_comb begin
    imem_win = i_imem_req && (!i_dmem_req || (starve_cnt == LIMIT));
    dmem_win = i_dmem_req && !imem_win;
    imem_gnt = imem_win && i_mem_ready && !i_reset;
    dmem_gnt = dmem_win && i_mem_ready && !i_reset;
  end

  assign o_imem_gnt = imem_gnt;
  assign o_dmem_gnt = dmem_gnt;
  assign o_mem_req  = (i_imem_req || i_dmem_req) && !i_reset;

  // Without a grant the bus shows dmem whenever it is asking, so a stalled store stays visible.
  always_comb begin
    if (imem_gnt || !i_dmem_req) begin
      o_mem_addr    = i_imem_addr;
      o_mem_byte_en = SZ_WORD;
      o_mem_wr_en   = 1'b0;
      o_mem_wr_data = '0;
    end else begin
      o_mem_addr    = i_dmem_addr;
      o_mem_byte_en = i_dmem_byte_en;
      o_mem_wr_en   = i_dmem_wr_en;
      o_mem_wr_data = i_dmem_wr_data;
    end
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (!i_imem_req || imem_gnt)
      starve_nxt = '0;
    else if (i_mem_ready && (starve_cnt != LIMIT))
      starve_nxt = starve_cnt + 4'd1;
  end

  always_comb begin
    rd_owner_nxt = OWN_NONE;
    if (imem_gnt)
      rd_owner_nxt = OWN_IMEM;
    else if (dmem_gnt && !i_dmem_wr_en)
      rd_owner_nxt = OWN_DMEM;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      starve_cnt <= '0;
      rd_owner   <= OWN_NONE;
    end else begin
      starve_cnt <= starve_nxt;
      rd_owner   <= rd_owner_nxt;
    end
  end

  // Gated by reset so a read granted just before reset never surfaces.
  assign o_imem_rvalid = (rd_owner == OWN_IMEM) && !i_reset;
  assign o_dmem_rvalid = (rd_owner == OWN_DMEM) && !i_reset;
  assign o_imem_rdata  = o_imem_rvalid ? i_mem_rdata : '0;
  assign o_dmem_rdata  = o_dmem_rvalid ? i_mem_rdata : '0;

endmodule

// File: tb/tb_sparrow_mem_arbiter.sv
// Directed self-checking bench for sparrow_mem_arbiter (STARVE_LIMIT = 4, DATA_W = 32).
module tb_sparrow_mem_arbiter;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_imem_req;
  logic [31:0] i_imem_addr;
  logic        o_imem_gnt, o_imem_rvalid;
  logic [31:0] o_imem_rdata;
  logic        i_dmem_req;
  logic [31:0] i_dmem_addr;
  logic [1:0]  i_dmem_byte_en;
  logic        i_dmem_wr_en;
  logic [31:0] i_dmem_wr_data;
  logic        o_dmem_gnt, o_dmem_rvalid;
  logic [31:0] o_dmem_rdata;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic [1:0]  o_mem_byte_en;
  logic        o_mem_wr_en;
  logic [31:0] o_mem_wr_data;
  logic        i_mem_ready;
  logic [31:0] i_mem_rdata;

  int checks = 0;
  int errors = 0;

  sparrow_mem_arbiter #(.STARVE_LIMIT(4), .DATA_W(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_imem_req(i_imem_req), .i_imem_addr(i_imem_addr),
    .o_imem_gnt(o_imem_gnt), .o_imem_rvalid(o_imem_rvalid), .o_imem_rdata(o_imem_rdata),
    .i_dmem_req(i_dmem_req), .i_dmem_addr(i_dmem_addr), .i_dmem_byte_en(i_dmem_byte_en),
    .i_dmem_wr_en(i_dmem_wr_en), .i_dmem_wr_data(i_dmem_wr_data),
    .o_dmem_gnt(o_dmem_gnt), .o_dmem_rvalid(o_dmem_rvalid), .o_dmem_rdata(o_dmem_rdata),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .o_mem_byte_en(o_mem_byte_en),
    .o_mem_wr_en(o_mem_wr_en), .o_mem_wr_data(o_mem_wr_data),
    .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are then driven 1 ns after the edge and checked 1 ns later.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_imem_req = 0; i_imem_addr = 32'h0;
    i_dmem_req = 0; i_dmem_addr = 32'h0; i_dmem_byte_en = SZ_WORD;
    i_dmem_wr_en = 0; i_dmem_wr_data = 32'h0;
  endtask

  initial begin
    logic [3:0] exp_cnt [6];
    exp_cnt[0] = 4'd0; exp_cnt[1] = 4'd1; exp_cnt[2] = 4'd2;
    exp_cnt[3] = 4'd3; exp_cnt[4] = 4'd4; exp_cnt[5] = 4'd0;

    // Reset with both requesting: everything must stay quiet.
    idle();
    i_reset = 1; i_mem_ready = 1; i_mem_rdata = 32'hFFFF_FFFF;
    i_imem_req = 1; i_dmem_req = 1;
    step(); step();
    #1;
    chk("rst_imem_gnt", 32'(o_imem_gnt), 32'd0);
    chk("rst_dmem_gnt", 32'(o_dmem_gnt), 32'd0);
    chk("rst_mem_req", 32'(o_mem_req), 32'd0);
    chk("rst_imem_rvalid", 32'(o_imem_rvalid), 32'd0);
    chk("rst_dmem_rdata", o_dmem_rdata, 32'd0);
    chk("rst_starve", 32'(dut.starve_cnt), 32'd0);

    // imem-only fetch.
    step();
    i_reset = 0; idle();
    i_imem_req = 1; i_imem_addr = 32'h1000; i_mem_rdata = 32'h0;
    #1;
    chk("if_gnt", 32'(o_imem_gnt), 32'd1);
    chk("if_dgnt", 32'(o_dmem_gnt), 32'd0);
    chk("if_addr", o_mem_addr, 32'h1000);
    chk("if_wr_en", 32'(o_mem_wr_en), 32'd0);
    chk("if_byte_en", 32'(o_mem_byte_en), 32'(SZ_WORD));
    step();
    idle(); i_mem_rdata = 32'h0050_0093;
    #1;
    chk("if_rvalid", 32'(o_imem_rvalid), 32'd1);
    chk("if_rdata", o_imem_rdata, 32'h0050_0093);
    chk("if_dvalid", 32'(o_dmem_rvalid), 32'd0);
    chk("if_drdata", o_dmem_rdata, 32'd0);

    // Contention: dmem wins four times, then imem is forced through.
    for (int c = 0; c < 6; c++) begin
      step();
      i_imem_req = 1; i_imem_addr = 32'h1000;
      i_dmem_req = 1; i_dmem_addr = 32'h200; i_dmem_wr_en = 0; i_dmem_byte_en = SZ_WORD;
      i_mem_rdata = 32'hA000_0000 + 32'(c);
      #1;
      chk($sformatf("ct_imem_gnt%0d", c), 32'(o_imem_gnt), (c == 4) ? 32'd1 : 32'd0);
      chk($sformatf("ct_dmem_gnt%0d", c), 32'(o_dmem_gnt), (c == 4) ? 32'd0 : 32'd1);
      chk($sformatf("ct_starve%0d", c), 32'(dut.starve_cnt), 32'(exp_cnt[c]));
      chk($sformatf("ct_addr%0d", c), o_mem_addr, (c == 4) ? 32'h1000 : 32'h200);
      chk($sformatf("ct_ivalid%0d", c), 32'(o_imem_rvalid), (c == 5) ? 32'd1 : 32'd0);
      chk($sformatf("ct_dvalid%0d", c), 32'(o_dmem_rvalid), (c == 0 || c == 5) ? 32'd0 : 32'd1);
    end
    step();
    idle(); i_mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("ct_tail_dvalid", 32'(o_dmem_rvalid), 32'd1);
    chk("ct_tail_drdata", o_dmem_rdata, 32'hDEAD_BEEF);
    chk("ct_tail_irdata", o_imem_rdata, 32'd0);

    // Byte store: no response follows.
    step();
    i_dmem_req = 1; i_dmem_wr_en = 1; i_dmem_byte_en = SZ_BYTE;
    i_dmem_addr = 32'h203; i_dmem_wr_data = 32'hAB;
    #1;
    chk("st_gnt", 32'(o_dmem_gnt), 32'd1);
    chk("st_wr_en", 32'(o_mem_wr_en), 32'd1);
    chk("st_addr", o_mem_addr, 32'h203);
    chk("st_byte_en", 32'(o_mem_byte_en), 32'(SZ_BYTE));
    chk("st_wr_data", o_mem_wr_data, 32'hAB);
    step();
    idle();
    #1;
    chk("st_no_dvalid", 32'(o_dmem_rvalid), 32'd0);
    chk("st_no_ivalid", 32'(o_imem_rvalid), 32'd0);

    // Illegal size code passes straight through.
    step();
    i_dmem_req = 1; i_dmem_byte_en = 2'b11; i_dmem_addr = 32'h40;
    #1;
    chk("bad_sz_byte_en", 32'(o_mem_byte_en), 32'd3);

    // Memory stall: one win for dmem (starve -> 1), then three not-ready cycles.
    step();
    idle();
    i_imem_req = 1; i_imem_addr = 32'h1000;
    i_dmem_req = 1; i_dmem_addr = 32'h200; i_dmem_byte_en = SZ_WORD;
    #1;
    chk("stl_pre_dgnt", 32'(o_dmem_gnt), 32'd1);
    for (int s = 0; s < 3; s++) begin
      step();
      i_mem_ready = 0;
      #1;
      chk($sformatf("stl_igrant%0d", s), 32'(o_imem_gnt), 32'd0);
      chk($sformatf("stl_dgrant%0d", s), 32'(o_dmem_gnt), 32'd0);
      chk($sformatf("stl_req%0d", s), 32'(o_mem_req), 32'd1);
      chk($sformatf("stl_starve%0d", s), 32'(dut.starve_cnt), 32'd1);
      chk($sformatf("stl_addr%0d", s), o_mem_addr, 32'h200);
      chk($sformatf("stl_dvalid%0d", s), 32'(o_dmem_rvalid), (s == 0) ? 32'd1 : 32'd0);
    end
    step();
    i_mem_ready = 1;
    #1;
    chk("stl_resume_dgnt", 32'(o_dmem_gnt), 32'd1);
    chk("stl_resume_starve", 32'(dut.starve_cnt), 32'd1);
    step();
    idle();
    #1;
    chk("stl_after_starve", 32'(dut.starve_cnt), 32'd2);

    // Interleaved reads: imem then dmem.
    step();
    i_imem_req = 1; i_imem_addr = 32'h1004;
    #1;
    chk("il_igrant", 32'(o_imem_gnt), 32'd1);
    step();
    idle(); i_dmem_req = 1; i_dmem_addr = 32'h208; i_mem_rdata = 32'h1111_1111;
    #1;
    chk("il_dgrant", 32'(o_dmem_gnt), 32'd1);
    chk("il_ivalid", 32'(o_imem_rvalid), 32'd1);
    chk("il_irdata", o_imem_rdata, 32'h1111_1111);
    chk("il_drdata0", o_dmem_rdata, 32'd0);
    step();
    idle(); i_mem_rdata = 32'h2222_2222;
    #1;
    chk("il_dvalid", 32'(o_dmem_rvalid), 32'd1);
    chk("il_drdata", o_dmem_rdata, 32'h2222_2222);
    chk("il_ivalid2", 32'(o_imem_rvalid), 32'd0);
    chk("il_irdata2", o_imem_rdata, 32'd0);

    // Reset right after an imem grant swallows the response.
    step();
    i_imem_req = 1; i_imem_addr = 32'h1008;
    #1;
    chk("mr_igrant", 32'(o_imem_gnt), 32'd1);
    step();
    i_reset = 1; i_mem_rdata = 32'h3333_3333;
    #1;
    chk("mr_ivalid", 32'(o_imem_rvalid), 32'd0);
    chk("mr_irdata", o_imem_rdata, 32'd0);
    chk("mr_igrant_rst", 32'(o_imem_gnt), 32'd0);
    chk("mr_req_rst", 32'(o_mem_req), 32'd0);
    step();
    #1;
    chk("mr_ivalid2", 32'(o_imem_rvalid), 32'd0);
    chk("mr_starve", 32'(dut.starve_cnt), 32'd0);
    step();
    i_reset = 0; idle();
    #1;
    chk("mr_ivalid3", 32'(o_imem_rvalid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sparrow_mem_arbiter.md
Name: sparrow_mem_arbiter

Overview:
- Shares one single-port unified memory between the sparrow core's instruction-fetch port and data port.
- Per-cycle fixed-priority arbitration: data wins by default; a starvation counter forces an instruction grant after STARVE_LIMIT consecutive losses.
- Tracks which requester owns each outstanding read and routes the one-cycle-latency read data back to that requester.
- Sits between sparrow_top's imem/dmem ports and the memory model or SRAM macro.

Parameters:
- STARVE_LIMIT, 4, consecutive cycles imem may be denied while requesting before it is forced to win; legal range 1..15.
- DATA_W, 32, data width; addresses fixed at 32 bits.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_imem_req  in  1  instruction read request
- i_imem_addr  in  32  fetch byte address
- o_imem_gnt  out  1  imem request accepted this cycle
- o_imem_rvalid  out  1  fetch data valid
- o_imem_rdata  out  DATA_W  fetch data
- i_dmem_req  in  1  data request
- i_dmem_addr  in  32  data byte address
- i_dmem_byte_en  in  2  size code: BYTE / HALF_WORD / WORD (sparrow_pkg encoding)
- i_dmem_wr_en  in  1  1 = store, 0 = load
- i_dmem_wr_data  in  DATA_W  store data
- o_dmem_gnt  out  1  dmem request accepted this cycle
- o_dmem_rvalid  out  1  load data valid
- o_dmem_rdata  out  DATA_W  load data
- o_mem_req  out  1  memory request
- o_mem_addr  out  32  memory address
- o_mem_byte_en  out  2  size code passed through
- o_mem_wr_en  out  1  write enable
- o_mem_wr_data  out  DATA_W  write data
- i_mem_ready  in  1  memory can accept a request this cycle
- i_mem_rdata  in  DATA_W  read data, valid the cycle after an accepted read

Behaviour:
- Accept condition: a request is accepted in a cycle when o_mem_req && i_mem_ready.
- Grants are combinational and only ever asserted while i_mem_ready = 1. At most one grant is high per cycle.
- Priority when both requesters are active and i_mem_ready = 1:
  - dmem wins if starve_cnt < STARVE_LIMIT.
  - imem wins if starve_cnt == STARVE_LIMIT.
- When only one requester is active, it wins.
- o_mem_* is a mux of the winner's fields.
- o_mem_req = i_imem_req | i_dmem_req, regardless of i_mem_ready.
- With no winner, o_mem_* holds the dmem fields when i_dmem_req = 1, otherwise the imem fields.
- imem drives: wr_en = 0, byte_en = WORD, wr_data = 0.
- starve_cnt register, width 4:
  - Increments by 1 (saturating at STARVE_LIMIT) on cycles with i_imem_req && !o_imem_gnt && i_mem_ready.
  - Clears on o_imem_gnt or !i_imem_req.
  - Holds while !i_mem_ready.
- Response tracking: register rd_owner in {NONE, IMEM, DMEM}.
  - Next value = IMEM on an imem grant, DMEM on a dmem read grant, otherwise NONE.
  - Dmem store grants produce no response.
- Responses, in the cycle after the grant:
  - o_imem_rvalid = (rd_owner == IMEM).
  - o_dmem_rvalid = (rd_owner == DMEM).
  - The owner's rdata = i_mem_rdata; the non-owner's rdata = 0.
- Back-to-back grants are legal every cycle. A response and a new grant may occur in the same cycle.
- Requester contract: the requester holds req and all fields stable until granted. The arbiter does not latch request fields.
- Reset, evaluated synchronously at the clock edge:
  - starve_cnt = 0, rd_owner = NONE, both rvalid = 0, both rdata = 0.
  - While i_reset = 1: grants = 0 and o_mem_req = 0, with inputs ignored.
  - A read granted in the cycle before reset asserts produces no rvalid.
- A dmem request with byte_en outside the three legal codes is passed through unchanged; checking it is the memory's job.

Test Plan:
- imem-only: i_imem_req = 1, addr 0x1000, i_mem_ready = 1, memory returns 0x00500093.
  -> o_imem_gnt = 1 in cycle 0; o_imem_rvalid = 1 with rdata 0x00500093 in cycle 1; o_dmem_rvalid = 0.
- Contention: both requesting continuously, dmem load addr 0x200, STARVE_LIMIT = 4.
  -> dmem granted cycles 0–3, imem granted cycle 4, dmem cycle 5; starve_cnt reads 0,1,2,3,4,0.
- Store: dmem wr_en = 1, byte_en = BYTE, addr 0x203, data 0xAB.
  -> o_mem_wr_en = 1, o_mem_addr = 0x203, o_mem_byte_en = BYTE, o_dmem_gnt = 1; no o_dmem_rvalid in the next cycle.
- Memory stall: i_mem_ready = 0 for 3 cycles with both requesting.
  -> no grants; o_mem_req = 1; starve_cnt holds; normal arbitration resumes when ready returns.
- Interleaved reads: imem grant in cycle 0, dmem load grant in cycle 1.
  -> cycle 1: o_imem_rvalid = 1; cycle 2: o_dmem_rvalid = 1 with i_mem_rdata routed to dmem only.
- Reset mid-operation: imem granted in cycle 0, i_reset = 1 in cycle 1.
  -> o_imem_rvalid = 0 in cycle 1 and after; starve_cnt = 0; grants = 0 while reset is held.
